uart_tx_sched: RTL and testbench

//   Shares one UART transmit line among N_REQ requesters. Round-robin arbitration;
//   the granted byte is serialized as 8N1 (or 8N2) frames. The bit timing comes from
//   the external baud tick generator. At each frame start this block pulses that

---
 rtl/uart_tx_sched.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART TX line among N_REQ byte sources.
// Frames are 8N1/8N2; the external baud generator is restarted at every frame start.
//
// state | meaning
// IDLE  | line high, waiting for any request
// START | start bit on the line, waiting for first baud tick
// DATA  | shifting data bits LSB first, one per tick
// STOP  | stop bit(s) on the line, counting ticks
module uart_tx_sched #(
   parameter int N_REQ     = 2,
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1,
   parameter int ID_W      = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ*DATA_W-1:0] i_data,
   output logic [N_REQ-1:0]        o_ack,
   input  logic                    i_baud_tick,
   output logic                    o_baud_srst,
   output logic                    o_txd,
   output logic                    o_busy,
   output logic [ID_W-1:0]         o_grant_id
);

   localparam int BIT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t state, state_nxt;

   logic              txd_nxt;
   logic [N_REQ-1:0]  ack_nxt;
   logic              srst_nxt;
   logic              busy_nxt;
   logic [ID_W-1:0]   gid_nxt;
   logic [ID_W-1:0]   rr_ptr, rr_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt, shifted;
   logic [BIT_W-1:0]  bitcnt, bitcnt_nxt;
   logic              stopcnt, stopcnt_nxt;

   logic              hi_valid, lo_valid, grant_valid;
   logic [ID_W-1:0]   hi_idx, lo_idx, grant_idx;
   logic [N_REQ-1:0]  grant_onehot;
   logic [DATA_W-1:0] grant_data;
   logic              tick_ok;

   // Scanning downward leaves the lowest set index; the "hi" search only
   // considers requesters at or after the pointer, "lo" is the wrap-around fallback.
   always_comb begin
      hi_valid = 1'b0;
      hi_idx   = '0;
      lo_valid = 1'b0;
      lo_idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (i_req[k]) begin
            lo_valid = 1'b1;
            lo_idx   = ID_W'(k);
            if (ID_W'(k) >= rr_ptr) begin
               hi_valid = 1'b1;
               hi_idx   = ID_W'(k);
            end
         end
      end
   end

   assign grant_valid = lo_valid;
   assign grant_idx   = hi_valid ? hi_idx : lo_idx;

   always_comb begin
      grant_onehot = '0;
      grant_data   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (ID_W'(k) == grant_idx) begin
            grant_onehot[k] = 1'b1;
            grant_data      = i_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // A tick landing while the generator is being restarted belongs to the old phase.
   assign tick_ok = i_baud_tick && !o_baud_srst;
   assign shifted = shreg >> 1;

   always_comb begin
      state_nxt   = state;
      txd_nxt     = o_txd;
      ack_nxt     = '0;
      srst_nxt    = 1'b0;
      busy_nxt    = o_busy;
      gid_nxt     = o_grant_id;
      rr_nxt      = rr_ptr;
      shreg_nxt   = shreg;
      bitcnt_nxt  = bitcnt;
      stopcnt_nxt = stopcnt;
      case (state)
         ST_IDLE: begin
            if (grant_valid) begin
               state_nxt = ST_START;
               txd_nxt   = 1'b0;
               ack_nxt   = grant_onehot;
               srst_nxt  = 1'b1;
               busy_nxt  = 1'b1;
               gid_nxt   = grant_idx;
               shreg_nxt = grant_data;
               rr_nxt    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
         end
         ST_START: begin
            if (tick_ok) begin
               state_nxt  = ST_DATA;
               txd_nxt    = shreg[0];
               bitcnt_nxt = '0;
            end
         end
         ST_DATA: begin
            if (tick_ok) begin
               if (bitcnt == BIT_W'(DATA_W - 1)) begin
                  state_nxt   = ST_STOP;
                  txd_nxt     = 1'b1;
                  stopcnt_nxt = 1'b0;
               end else begin
                  shreg_nxt  = shifted;
                  txd_nxt    = shifted[0];
                  bitcnt_nxt = bitcnt + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (tick_ok) begin
               if (stopcnt == 1'(STOP_BITS - 1)) begin
                  state_nxt = ST_IDLE;
                  busy_nxt  = 1'b0;
               end else begin
                  stopcnt_nxt = stopcnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            txd_nxt   = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         o_txd       <= 1'b1;
         o_ack       <= '0;
         o_baud_srst <= 1'b0;
         o_busy      <= 1'b0;
         o_grant_id  <= '0;
         rr_ptr      <= '0;
         shreg       <= '0;
         bitcnt      <= '0;
         stopcnt     <= 1'b0;
      end else begin
         state       <= state_nxt;
         o_txd       <= txd_nxt;
         o_ack       <= ack_nxt;
         o_baud_srst <= srst_nxt;
         o_busy      <= busy_nxt;
         o_grant_id  <= gid_nxt;
         rr_ptr      <= rr_nxt;
         shreg       <= shreg_nxt;
         bitcnt      <= bitcnt_nxt;
         stopcnt     <= stopcnt_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: two instances (2 req/1 stop, 3 req/2 stop) driven by
// stub baud generators; expected frames come from a round-robin + 8N1/8N2 model.
module tb_uart_tx_sched;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]  req0, ack0;
   logic [15:0] data0;
   logic        tick0, srst0, txd0, busy0;
   logic [0:0]  gid0;

   logic [2:0]  req1, ack1;
   logic [23:0] data1;
   logic        tick1, srst1, txd1, busy1;
   logic [1:0]  gid1;

   logic [1:0]  cnt0, cnt1;
   logic        force_tick;

   uart_tx_sched #(.N_REQ(2), .DATA_W(8), .STOP_BITS(1), .ID_W(1)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_req(req0), .i_data(data0), .o_ack(ack0),
      .i_baud_tick(tick0), .o_baud_srst(srst0), .o_txd(txd0), .o_busy(busy0),
      .o_grant_id(gid0));

   uart_tx_sched #(.N_REQ(3), .DATA_W(8), .STOP_BITS(2), .ID_W(2)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_req(req1), .i_data(data1), .o_ack(ack1),
      .i_baud_tick(tick1), .o_baud_srst(srst1), .o_txd(txd1), .o_busy(busy1),
      .o_grant_id(gid1));

   // Stub generators: first tick 3 clks after the restart pulse, then every 4 clks,
   // which gives a 4-clk start bit and 4-clk data/stop bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt0 <= 2'd0;
      else if (srst0) cnt0 <= 2'd1;
      else            cnt0 <= cnt0 + 2'd1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt1 <= 2'd0;
      else if (srst1) cnt1 <= 2'd1;
      else            cnt1 <= cnt1 + 2'd1;
   end
   assign tick0 = (cnt0 == 2'd3) | force_tick;
   assign tick1 = (cnt1 == 2'd3);

   logic       sel;
   logic [2:0] m_ack;
   logic [1:0] m_gid;
   logic       m_txd, m_busy;
   assign m_ack  = sel ? ack1  : {1'b0, ack0};
   assign m_gid  = sel ? gid1  : {1'b0, gid0};
   assign m_txd  = sel ? txd1  : txd0;
   assign m_busy = sel ? busy1 : busy0;

   int errors = 0;
   int checks = 0;
   int ptr[2];
   int lat;
   int quiet_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model one granted frame: pick the requester round-robin from the driven
   // request mask, then expect start bit, 8 data bits LSB first, stop bit(s),
   // each 4 clocks, followed by an idle-high cycle with busy low.
   task automatic run_frame(input bit s, input bit drop, input bit pulse, input bit ftick);
      int n, g, nbits, wave_err, busy_err, ack_err;
      logic [2:0] mask;
      logic [7:0] d;
      logic       expb;
      sel = s;
      n = s ? 3 : 2;
      mask = s ? req1 : {1'b0, req0};
      g = -1;
      for (int i = 0; i < n; i++) begin
         int k;
         k = (ptr[s] + i) % n;
         if (g < 0 && mask[k]) g = k;
      end
      if (g < 0) g = 0;
      d = s ? data1[g*8 +: 8] : data0[g*8 +: 8];
      ptr[s] = (g + 1) % n;
      nbits = s ? 11 : 10;
      if (ftick) force_tick = 1'b1;
      lat = 0;
      while (m_ack == 3'b000 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check("grant_latency", lat, 1);
      check("ack_vector", {29'd0, m_ack}, 32'd1 << g);
      check("grant_id", {30'd0, m_gid}, g);
      if (drop) begin
         if (s) req1[g] = 1'b0; else req0[g] = 1'b0;
         data0 = 16'($urandom);
         data1 = 24'($urandom);
      end
      wave_err = 0; busy_err = 0; ack_err = 0;
      for (int k = 0; k < nbits * 4; k++) begin
         if (k < 4)       expb = 1'b0;
         else if (k < 36) expb = d[(k - 4) / 4];
         else             expb = 1'b1;
         if (m_txd !== expb) wave_err++;
         if (m_busy !== 1'b1) busy_err++;
         if (m_ack !== ((k == 0) ? (3'b001 << g) : 3'b000)) ack_err++;
         if (k == 0) force_tick = 1'b0;
         if (pulse && k == 8) req0[1] = 1'b1;
         if (pulse && k == 9) req0[1] = 1'b0;
         @(negedge clk);
      end
      check("txd_waveform_errs", wave_err, 0);
      check("busy_in_frame_errs", busy_err, 0);
      check("ack_pulse_errs", ack_err, 0);
      check("busy_after_frame", {31'd0, m_busy}, 0);
      check("txd_idle_after_frame", {31'd0, m_txd}, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req0 = '0; req1 = '0; data0 = '0; data1 = '0;
      force_tick = 1'b0;
      sel = 1'b0;
      ptr[0] = 0; ptr[1] = 0;
      repeat (2) @(negedge clk);
      check("rst_txd0", {31'd0, txd0}, 1);
      check("rst_busy0", {31'd0, busy0}, 0);
      check("rst_ack0", {30'd0, ack0}, 0);
      check("rst_srst0", {31'd0, srst0}, 0);
      check("rst_gid0", {31'd0, gid0}, 0);
      check("rst_txd1", {31'd0, txd1}, 1);
      check("rst_busy1", {31'd0, busy1}, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Two held requests alternate 0,1,0,1.
      req0 = 2'b11; data0 = 16'hFF00;
      for (int i = 0; i < 4; i++) begin
         run_frame(1'b0, 1'b0, 1'b0, 1'b0);
         check("rr_order", {31'd0, gid0}, i % 2);
      end
      req0 = 2'b00;
      repeat (2) @(negedge clk);

      // Single byte 0xA5.
      req0 = 2'b01; data0 = 16'h00A5;
      run_frame(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("gid_holds_after_frame", {31'd0, gid0}, 0);

      // One-cycle request pulse from requester 1 during a frame is never served.
      req0 = 2'b01; data0 = 16'($urandom);
      run_frame(1'b0, 1'b1, 1'b1, 1'b0);
      quiet_err = 0;
      for (int k = 0; k < 8; k++) begin
         if (ack0 !== 2'b00 || busy0 !== 1'b0) quiet_err++;
         @(negedge clk);
      end
      check("no_frame_for_withdrawn_req", quiet_err, 0);

      // Tick forced with the request cycle and the restart pulse.
      req0 = 2'b10; data0 = 16'($urandom);
      run_frame(1'b0, 1'b1, 1'b0, 1'b1);

      // Reset in the middle of data bit 3.
      sel = 1'b0;
      req0 = 2'b01; data0 = 16'($urandom);
      lat = 0;
      while (ack0 == 2'b00 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check("pre_rst_ack", {30'd0, ack0}, 1);
      req0 = 2'b00;
      repeat (17) @(negedge clk);
      check("pre_rst_busy", {31'd0, busy0}, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_txd", {31'd0, txd0}, 1);
      check("mid_rst_busy", {31'd0, busy0}, 0);
      @(negedge clk);
      rst = 1'b0;
      ptr[0] = 0; ptr[1] = 0;
      repeat (2) @(negedge clk);
      req0 = 2'b10; data0 = 16'($urandom);
      run_frame(1'b0, 1'b1, 1'b0, 1'b0);

      // Two stop bits with 0x55.
      req1 = 3'b010; data1 = 24'h555555;
      run_frame(1'b1, 1'b1, 1'b0, 1'b0);

      // Random request masks and bytes on both instances.
      for (int i = 0; i < 8; i++) begin
         req1 = 3'($urandom_range(1, 7));
         data1 = 24'($urandom);
         run_frame(1'b1, 1'b1, 1'b0, 1'b0);
      end
      req1 = 3'b000;
      for (int i = 0; i < 4; i++) begin
         req0 = 2'($urandom_range(1, 3));
         data0 = 16'($urandom);
         run_frame(1'b0, 1'b1, 1'b0, 1'b0);
      end
      req0 = 2'b00;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
